// File: rtl/alu_pkg.sv
// Shared types for the ALU and its upstream sequencer.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    SUB  = 2'd0,
    ADD  = 2'd1,
    NAND = 2'd2
  } op_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu.sv
// Purpose: 8-bit combinational ALU (SUB b-a, ADD, NAND; op 3 yields zero result).
// Latency: combinational, no state.
// Backpressure: none; outputs follow inputs every cycle.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] out,
  output logic              zero,
  output logic              carry
);

  always_comb begin
    out   = '0;
    carry = 1'b0;
    case (op)
      // carry out of b + ~a + 1 is the "no borrow" indication
      SUB:     {carry, out} = {1'b0, b} + {1'b0, ~a} + 9'd1;
      ADD:     {carry, out} = {1'b0, a} + {1'b0, b};
      NAND:    out = ~(a & b);
      default: out = '0;
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/alu_regfile.sv
// Purpose: REG_COUNT x 8 register file, one write port, three combinational read ports.
// Latency: write visible on reads the cycle after the write edge.
// Backpressure: none; the write port always accepts.
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int REG_COUNT = 4,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_data,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign a_data   = regs[a_addr];
  assign b_data   = regs[b_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Purpose: owns regfile + flags, runs one ALU command at a time (IDLE->READ->EXEC->WRITE).
// Latency: handshake cycle N, done/writeback in cycle N+3, next command accepted from N+4.
// Backpressure: cmd_ready/ld_ready low while busy; a pending load blocks commands in IDLE.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter  int REG_COUNT = 4,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              cmd_setf,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              carry_flag
);

  seq_state_t state, state_nxt;

  logic [1:0]        op_q;
  logic [ADDR_W-1:0] ra_q, rb_q, rd_q;
  logic              setf_q;
  logic [DATA_W-1:0] hold_out;
  logic              hold_zero, hold_carry;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_a, rf_b;

  alu_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .a_addr   (ra_q),
    .a_data   (rf_a),
    .b_addr   (rb_q),
    .b_data   (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    ld_ready  = 1'b0;
    done      = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = ld_addr;
    rf_wdata  = ld_data;
    case (state)
      IDLE: begin
        // a pending load takes the single write port, so the command waits
        ld_ready  = 1'b1;
        cmd_ready = ~ld_valid;
        rf_we     = ld_valid;
        if (cmd_valid && !ld_valid) state_nxt = READ;
      end
      READ:  state_nxt = EXEC;
      EXEC:  state_nxt = WRITE;
      WRITE: begin
        done      = 1'b1;
        rf_we     = 1'b1;
        rf_waddr  = rd_q;
        rf_wdata  = hold_out;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rd_q       <= '0;
      setf_q     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      hold_out   <= '0;
      hold_zero  <= 1'b0;
      hold_carry <= 1'b0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && !ld_valid) begin
            op_q   <= cmd_op;
            ra_q   <= cmd_ra;
            rb_q   <= cmd_rb;
            rd_q   <= cmd_rd;
            setf_q <= cmd_setf;
          end
        end
        READ: begin
          alu_a  <= rf_a;
          alu_b  <= rf_b;
          alu_op <= op_q;
        end
        EXEC: begin
          hold_out   <= alu_out;
          hold_zero  <= alu_zero;
          hold_carry <= alu_carry;
        end
        WRITE: begin
          result <= hold_out;
          if (setf_q) begin
            zero_flag  <= hold_zero;
            carry_flag <= hold_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: stimulus pushes model-predicted writebacks, a monitor checks each done pulse.
module tb_alu_sequencer;

  localparam int RC = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_setf;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_ra, cmd_rb, cmd_rd;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic [AW-1:0] dbg_addr, stim_dbg, mon_dbg;
  logic          dbg_own;
  logic [7:0]    dbg_data;
  logic [7:0]    alu_a, alu_b, alu_out, result;
  logic [1:0]    alu_op;
  logic          alu_zero, alu_carry, done, zero_flag, carry_flag;

  always #5 clk = ~clk;

  assign dbg_addr = dbg_own ? stim_dbg : mon_dbg;

  alu_sequencer #(.REG_COUNT(RC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_setf(cmd_setf),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .done(done), .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  alu u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op),
    .out(alu_out), .zero(alu_zero), .carry(alu_carry)
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [7:0]    res;
    logic          fz;
    logic          fc;
    int            cyc;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  logic [7:0] mreg [RC];
  logic       mz, mc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Reference: operands taken from model registers, result from plain arithmetic.
  task automatic expect_cmd(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                            input logic [AW-1:0] rd, input logic setf, input int hs);
    int   a, b, r;
    logic c;
    exp_t e;
    a = int'(mreg[ra]);
    b = int'(mreg[rb]);
    case (op)
      2'd0:    begin r = b - a;          c = (b >= a); end
      2'd1:    begin r = a + b;          c = (r > 255); end
      2'd2:    begin r = 255 - (a & b);  c = 1'b0;     end
      default: begin r = 0;              c = 1'b0;     end
    endcase
    r = r & 255;
    mreg[rd] = r[7:0];
    if (setf) begin
      mz = (r == 0);
      mc = c;
    end
    e.rd = rd; e.res = r[7:0]; e.fz = mz; e.fc = mc; e.cyc = hs;
    sbq.push_back(e);
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [7:0] data);
    int n;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = addr; ld_data = data;
    #1;
    n = 0;
    while (!ld_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) timeout("load_ready");
    mreg[addr] = data;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rd, input logic setf, input bit push);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_setf = setf;
    #1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) timeout("cmd_ready");
    if (push) expect_cmd(op, ra, rb, rd, setf, cyc);
    @(posedge clk); #1;
    // scramble fields after handshake; the latched command must be unaffected
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_ra = AW'($urandom); cmd_rb = AW'($urandom);
    cmd_rd = AW'($urandom); cmd_setf = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!cmd_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) timeout("wait_idle");
  endtask

  initial begin : monitor
    exp_t e;
    mon_dbg = '0;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done pulse with no pending command (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("done_latency", cyc - e.cyc, 3);
          mon_dbg = e.rd;
          @(posedge clk); #1;
          check("result", result, e.res);
          check("zero_flag", zero_flag, e.fz);
          check("carry_flag", carry_flag, e.fc);
          check("reg_rd", dbg_data, e.res);
        end
      end
    end
  end

  initial begin : stim
    int prev, hs, n;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_setf = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    dbg_own = 1'b1; stim_dbg = '0;
    for (int i = 0; i < RC; i++) mreg[i] = '0;
    mz = 1'b0; mc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("rst_result", result, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_carry", carry_flag, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_done", done, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    for (int i = 0; i < RC; i++) begin
      stim_dbg = AW'(i); #1;
      check("rst_reg", dbg_data, 0);
    end
    dbg_own = 1'b0;

    // SUB 5-3 with no borrow
    load(1, 8'd3); load(2, 8'd5);
    issue(2'd0, 1, 2, 3, 1'b1, 1'b1);
    check("busy_cmd_ready", cmd_ready, 0);
    check("busy_ld_ready", ld_ready, 0);
    wait_idle();

    // SUB 3-5 with borrow
    load(1, 8'd5); load(2, 8'd3);
    issue(2'd0, 1, 2, 0, 1'b1, 1'b1);
    wait_idle();

    // ADD wrap to zero, then NAND without flag update
    load(1, 8'hFF); load(2, 8'h01);
    issue(2'd1, 1, 2, 1, 1'b1, 1'b1);
    wait_idle();
    load(1, 8'hF0); load(2, 8'hFF);
    issue(2'd2, 1, 2, 3, 1'b0, 1'b1);
    wait_idle();

    // load and command together: load wins, command follows one cycle later
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 0; ld_data = 8'h5A;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_ra = 0; cmd_rb = 0; cmd_rd = 2; cmd_setf = 1'b1;
    #1;
    check("collide_cmd_ready", cmd_ready, 0);
    check("collide_ld_ready", ld_ready, 1);
    mreg[0] = 8'h5A;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    #1;
    check("collide_cmd_next", cmd_ready, 1);
    expect_cmd(2'd1, 0, 0, 2, 1'b1, cyc);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();

    // reset during EXEC aborts the command
    issue(2'd1, 1, 2, 3, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_zero", zero_flag, 0);
    check("abort_carry", carry_flag, 0);
    check("abort_alu_a", alu_a, 0);
    for (int i = 0; i < RC; i++) mreg[i] = '0;
    mz = 1'b0; mc = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_done_after", done, 0);
    dbg_own = 1'b1;
    for (int i = 0; i < RC; i++) begin
      stim_dbg = AW'(i); #1;
      check("abort_reg", dbg_data, 0);
    end
    dbg_own = 1'b0;

    // back-to-back reserved ops with cmd_valid held
    load(1, 8'h77); load(2, 8'h12);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_setf = 1'b1;
    cmd_ra = AW'($urandom); cmd_rb = AW'($urandom); cmd_rd = AW'($urandom);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) timeout("b2b_ready");
      hs = cyc;
      if (k > 0) check("b2b_interval", hs - prev, 4);
      prev = hs;
      expect_cmd(2'd3, cmd_ra, cmd_rb, cmd_rd, 1'b1, hs);
      @(posedge clk); #1;
      cmd_ra = AW'($urandom); cmd_rb = AW'($urandom); cmd_rd = AW'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_idle();

    // randomized mix of loads and commands
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) load(AW'($urandom), 8'($urandom));
      issue(2'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), 1'b1);
      wait_idle();
    end

    n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("scoreboard_empty", sbq.size(), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
